// File: rtl/trdb_branch_map_mp.sv
// trdb_branch_map_mp
//   Packs up to BR_PER_CYCLE retired conditional branches per cycle into a
//   MAP_LEN-bit branch history (bit = 1 means NOT taken). In prediction mode,
//   correctly predicted branches that arrive while the map is still empty are
//   folded into a saturating counter instead of being stored.
//
// Ports
//   clk_i                      clock
//   rst_i                      synchronous active-high reset
//   valid_i                    per-lane branch retired, lane 0 oldest
//   branch_taken_i             per-lane outcome, 1 = taken
//   branch_taken_prediction_i  per-lane predicted outcome, 1 = taken
//   pred_mode_i                enable prediction counting
//   flush_i                    clear map/count/pbc, load this cycle's lanes
//   ready_o                    room for a full lane group
//   map_o                      branch history
//   branches_o                 number of valid bits in map_o
//   pbc_o                      correctly-predicted branch count
//   is_full_o                  branches_o == MAP_LEN
//   is_empty_o                 no branches stored and pbc_o == 0
module trdb_branch_map_mp #(
   parameter  int MAP_LEN      = 31,
   parameter  int BR_PER_CYCLE = 2,
   parameter  int PBC_W        = 16,
   localparam int CNT_W        = $clog2(MAP_LEN + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [BR_PER_CYCLE-1:0] valid_i,
   input  logic [BR_PER_CYCLE-1:0] branch_taken_i,
   input  logic [BR_PER_CYCLE-1:0] branch_taken_prediction_i,
   input  logic                    pred_mode_i,
   input  logic                    flush_i,
   output logic                    ready_o,
   output logic [MAP_LEN-1:0]      map_o,
   output logic [CNT_W-1:0]        branches_o,
   output logic [PBC_W-1:0]        pbc_o,
   output logic                    is_full_o,
   output logic                    is_empty_o
);

   localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(MAP_LEN - BR_PER_CYCLE);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAP_LEN);
   localparam logic [PBC_W-1:0] PBC_MAX   = '1;

   logic [MAP_LEN-1:0] map_q, map_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PBC_W-1:0]   pbc_q, pbc_d;
   logic               ready;
   logic               accept;
   logic               written;

   assign ready  = (cnt_q <= READY_LIM);
   assign accept = ready | flush_i;

   always_comb begin
      map_d   = map_q;
      cnt_d   = cnt_q;
      pbc_d   = pbc_q;
      written = 1'b0;
      if (accept) begin
         if (flush_i) begin
            map_d = '0;
            cnt_d = '0;
            pbc_d = '0;
         end
         // Counting only applies while nothing has been stored yet; the first
         // stored branch ends the predicted run for good.
         written = (cnt_d != '0);
         for (int i = 0; i < BR_PER_CYCLE; i++) begin
            if (valid_i[i]) begin
               if (pred_mode_i && !written &&
                   (branch_taken_i[i] == branch_taken_prediction_i[i]) &&
                   (pbc_d != PBC_MAX)) begin
                  pbc_d = pbc_d + PBC_W'(1);
               end else begin
                  // Bits at and above cnt_d are zero, so OR-ing places the bit.
                  map_d   = map_d | (MAP_LEN'(!branch_taken_i[i]) << cnt_d);
                  cnt_d   = cnt_d + CNT_W'(1);
                  written = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         map_q <= '0;
         cnt_q <= '0;
         pbc_q <= '0;
      end else begin
         map_q <= map_d;
         cnt_q <= cnt_d;
         pbc_q <= pbc_d;
      end
   end

   assign ready_o    = ready;
   assign map_o      = map_q;
   assign branches_o = cnt_q;
   assign pbc_o      = pbc_q;
   assign is_full_o  = (cnt_q == FULL_CNT);
   assign is_empty_o = (cnt_q == '0) && (pbc_q == '0);

   // Upstream must stall while the map cannot take a full lane group;
   // lanes offered then are dropped.
   stall_chk : assert property (@(posedge clk_i) disable iff (rst_i)
                                (valid_i != '0) |-> accept)
      else $warning("branch lanes offered while not ready; lanes dropped");

endmodule

// File: tb/tb_trdb_branch_map_mp.sv
module tb_trdb_branch_map_mp;

   localparam int ML = 31;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, flush, pm;
   logic [1:0] valid, taken, pred;

   logic        o0_ready, o0_full, o0_empty;
   logic [30:0] o0_map;
   logic [4:0]  o0_br;
   logic [15:0] o0_pbc;

   logic        o1_ready, o1_full, o1_empty;
   logic [30:0] o1_map;
   logic [4:0]  o1_br;
   logic [1:0]  o1_pbc;

   trdb_branch_map_mp #(.MAP_LEN(31), .BR_PER_CYCLE(2), .PBC_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .branch_taken_i(taken),
      .branch_taken_prediction_i(pred), .pred_mode_i(pm), .flush_i(flush),
      .ready_o(o0_ready), .map_o(o0_map), .branches_o(o0_br), .pbc_o(o0_pbc),
      .is_full_o(o0_full), .is_empty_o(o0_empty));

   trdb_branch_map_mp #(.MAP_LEN(31), .BR_PER_CYCLE(2), .PBC_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .branch_taken_i(taken),
      .branch_taken_prediction_i(pred), .pred_mode_i(pm), .flush_i(flush),
      .ready_o(o1_ready), .map_o(o1_map), .branches_o(o1_br), .pbc_o(o1_pbc),
      .is_full_o(o1_full), .is_empty_o(o1_empty));

   // Reference model: history as a bit array plus a count, pbc as an integer.
   logic [30:0] m_map [2];
   int          m_cnt [2];
   int          m_pbc [2];
   int          m_pmax[2];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_ready(input int d);
      return (ML - m_cnt[d]) >= 2;
   endfunction

   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_map[d] = '0; m_cnt[d] = 0; m_pbc[d] = 0;
         end else if (m_ready(d) || flush) begin
            if (flush) begin
               m_map[d] = '0; m_cnt[d] = 0; m_pbc[d] = 0;
            end
            for (int i = 0; i < 2; i++) begin
               if (valid[i]) begin
                  if (pm && m_cnt[d] == 0 && taken[i] == pred[i] && m_pbc[d] < m_pmax[d])
                     m_pbc[d]++;
                  else begin
                     m_map[d][m_cnt[d]] = !taken[i];
                     m_cnt[d]++;
                  end
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("d0_map",   64'(o0_map),   64'(m_map[0]));
      chk("d0_br",    64'(o0_br),    64'(m_cnt[0]));
      chk("d0_pbc",   64'(o0_pbc),   64'(m_pbc[0]));
      chk("d0_ready", 64'(o0_ready), 64'(m_ready(0)));
      chk("d0_full",  64'(o0_full),  64'(m_cnt[0] == ML));
      chk("d0_empty", 64'(o0_empty), 64'(m_cnt[0] == 0 && m_pbc[0] == 0));
      chk("d1_map",   64'(o1_map),   64'(m_map[1]));
      chk("d1_br",    64'(o1_br),    64'(m_cnt[1]));
      chk("d1_pbc",   64'(o1_pbc),   64'(m_pbc[1]));
      chk("d1_ready", 64'(o1_ready), 64'(m_ready(1)));
      chk("d1_full",  64'(o1_full),  64'(m_cnt[1] == ML));
      chk("d1_empty", 64'(o1_empty), 64'(m_cnt[1] == 0 && m_pbc[1] == 0));
   endtask

   task automatic step(input logic rs, input logic fl, input logic pm_in,
                       input logic [1:0] v, input logic [1:0] t, input logic [1:0] p);
      rst = rs; flush = fl; pm = pm_in; valid = v; taken = t; pred = p;
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   initial begin
      m_pmax[0] = 65535;
      m_pmax[1] = 3;
      for (int d = 0; d < 2; d++) begin
         m_map[d] = '0; m_cnt[d] = 0; m_pbc[d] = 0;
      end
      rst = 1'b1; flush = 1'b0; pm = 1'b0; valid = '0; taken = '0; pred = '0;

      // Reset values
      step(1, 0, 0, 2'b00, 2'b00, 2'b00);
      step(1, 0, 0, 2'b00, 2'b00, 2'b00);
      chk("rst_br",    64'(o0_br), 64'd0);
      chk("rst_empty", 64'(o0_empty), 64'd1);
      chk("rst_ready", 64'(o0_ready), 64'd1);

      // Two lanes, lane0 taken, lane1 not taken
      step(0, 0, 0, 2'b11, 2'b01, 2'b00);
      chk("t1_map",   64'(o0_map[1:0]), 64'b10);
      chk("t1_br",    64'(o0_br), 64'd2);
      chk("t1_empty", 64'(o0_empty), 64'd0);

      // Fill to 30 with single lanes, alternating outcomes
      for (int k = 0; k < 28; k++)
         step(0, 0, 0, 2'b01, {1'b0, k[0]}, 2'b00);
      chk("t2_br30", 64'(o0_br), 64'd30);
      chk("t2_nrdy", 64'(o0_ready), 64'd0);
      for (int k = 0; k < 3; k++)
         step(0, 0, 0, 2'b11, 2'b00, 2'b00);
      chk("t2_hold", 64'(o0_br), 64'd30);
      step(0, 1, 0, 2'b11, 2'b11, 2'b00);
      chk("t2_fl_br",  64'(o0_br), 64'd2);
      chk("t2_fl_map", 64'(o0_map), 64'd0);

      // Gap compaction: only lane1, not taken
      step(0, 1, 0, 2'b00, 2'b00, 2'b00);
      step(0, 0, 0, 2'b10, 2'b00, 2'b00);
      chk("t3_map", 64'(o0_map), 64'd1);
      chk("t3_br",  64'(o0_br), 64'd1);

      // Prediction counting
      step(0, 1, 1, 2'b00, 2'b00, 2'b00);
      for (int k = 0; k < 5; k++)
         step(0, 0, 1, 2'b11, 2'(k), 2'(k));
      chk("t4_pbc",   64'(o0_pbc), 64'd10);
      chk("t4_br",    64'(o0_br), 64'd0);
      chk("t4_empty", 64'(o0_empty), 64'd0);
      chk("t4_sat",   64'(o1_pbc), 64'd3);
      step(0, 0, 1, 2'b11, 2'b01, 2'b00);
      chk("t4_pbc2", 64'(o0_pbc), 64'd10);
      chk("t4_br2",  64'(o0_br), 64'd2);
      chk("t4_map2", 64'(o0_map[1:0]), 64'b10);

      // Saturation with PBC_W = 2
      step(0, 1, 1, 2'b00, 2'b00, 2'b00);
      for (int k = 0; k < 4; k++)
         step(0, 0, 1, 2'b01, 2'b01, 2'b01);
      chk("t5_pbc", 64'(o1_pbc), 64'd3);
      chk("t5_br",  64'(o1_br), 64'd1);

      // Reset beats flush and valid
      step(0, 1, 1, 2'b11, 2'b10, 2'b10);
      step(0, 0, 0, 2'b11, 2'b01, 2'b00);
      step(0, 0, 0, 2'b11, 2'b10, 2'b00);
      step(0, 0, 0, 2'b01, 2'b00, 2'b00);
      chk("t6_pre_br",  64'(o0_br), 64'd5);
      chk("t6_pre_pbc", 64'(o0_pbc), 64'd2);
      step(1, 1, 0, 2'b11, 2'b00, 2'b00);
      chk("t6_map",   64'(o0_map), 64'd0);
      chk("t6_br",    64'(o0_br), 64'd0);
      chk("t6_pbc",   64'(o0_pbc), 64'd0);
      chk("t6_empty", 64'(o0_empty), 64'd1);
      chk("t6_ready", 64'(o0_ready), 64'd1);

      // Randomized traffic, respecting the stall rule
      for (int k = 0; k < 400; k++) begin
         logic       r_rs, r_fl, r_pm;
         logic [1:0] r_v, r_t, r_p;
         r_rs = ($urandom_range(0, 99) == 0);
         r_fl = ($urandom_range(0, 9) == 0);
         r_pm = ($urandom_range(0, 3) != 0);
         r_v  = 2'($urandom);
         r_t  = 2'($urandom);
         r_p  = r_t ^ (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
         if (!r_fl && !(m_ready(0) && m_ready(1)))
            r_v = 2'b00;
         step(r_rs, r_fl, r_pm, r_v, r_t, r_p);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trdb_branch_map_mp.md
Name: trdb_branch_map_mp

Overview:
Parametrised multi-lane branch map for the trace encoder. It accepts up to BR_PER_CYCLE retired conditional branches per cycle and packs their outcomes into a MAP_LEN-bit history. An optional prediction mode folds leading correctly-predicted branches into a saturating count. The packet emitter reads map/count/pbc and pulses flush_i when it emits a branch packet.

Parameters:
MAP_LEN, 31, branch map capacity in bits (>= BR_PER_CYCLE)
BR_PER_CYCLE, 2, branch lanes retired per cycle (1..4)
PBC_W, 16, width of correctly-predicted branch counter
CNT_W, $clog2(MAP_LEN+1), width of branch count (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  BR_PER_CYCLE  per-lane branch retired; lane 0 oldest
branch_taken_i  in  BR_PER_CYCLE  per-lane outcome, 1 = taken
branch_taken_prediction_i  in  BR_PER_CYCLE  per-lane predicted outcome, 1 = taken
pred_mode_i  in  1  1 = enable prediction counting; sampled every cycle
flush_i  in  1  clear map, count and pbc (packet emitted)
ready_o  out  1  enough room for a full lane group
map_o  out  MAP_LEN  branch history; bit k = k-th stored branch, 1 = NOT taken
branches_o  out  CNT_W  number of valid bits in map_o
pbc_o  out  PBC_W  correctly-predicted branch count
is_full_o  out  1  branches_o == MAP_LEN
is_empty_o  out  1  branches_o == 0 and pbc_o == 0

Behaviour:
- Reset values: map_o = 0, branches_o = 0, pbc_o = 0, is_full_o = 0, is_empty_o = 1, ready_o = 1.
- All outputs are registered state, or combinational decodes of registered state only. Updates are visible the cycle after the input.
- ready_o = (MAP_LEN - branches_o) >= BR_PER_CYCLE. It does not depend on valid_i or flush_i.
- Accept condition: accept = ready_o | flush_i. With accept = 0, all valid lanes are ignored and state is held (unless rst_i is high). Upstream must stall; an SVA flags valid_i != 0 with accept = 0.
- Lane packing: accepted valid lanes are processed in ascending lane order. Invalid lanes are skipped, so any mask is legal. The n-th processed lane writes bit (base + n), where base = branches_o (or 0 when flush_i is high).
- Encoding: stored bit = ~branch_taken_i[lane] (E-trace convention).
- Prediction mode: with pred_mode_i = 1, a lane increments pbc instead of writing the map when all of the following hold:
  - its outcome equals its prediction;
  - no branch has yet been written to the map (current state and earlier lanes this cycle);
  - pbc < 2^PBC_W - 1.
  Otherwise the lane writes the map. Once any lane writes the map, all later lanes that cycle write the map.
- Prediction mode off: pbc is held. Every valid lane writes the map.
- flush_i: the map, count and pbc are cleared, and accepted lanes from the same cycle are inserted into the fresh map/pbc (flush-and-load). Bits above the new count are 0.
- Unused map bits (index >= branches_o) are always 0.
- rst_i has priority over flush_i and valid_i. Reset mid-operation discards all state and lanes of that cycle.
- Count arithmetic: branches_next = base + number of map-writing lanes. It never exceeds MAP_LEN by construction, because of the ready rule.

Test Plan:
1. Reset, then lane0 taken, lane1 not-taken in one cycle, pred off -> next cycle map_o[1:0] = 2'b10, branches_o = 2, is_empty_o = 0.
2. Single-lane inserts until branches_o = 30 (MAP_LEN 31) -> ready_o = 0. Hold valid_i = 2'b11 with flush_i = 0 -> state unchanged. Then assert flush_i with valid_i = 2'b11 (both taken) -> branches_o = 2, map_o = 0.
3. valid_i = 2'b10 only, lane1 not-taken, map empty -> map_o[0] = 1, branches_o = 1 (gap compaction).
4. pred_mode_i = 1, five cycles of both lanes correctly predicted -> pbc_o = 10, branches_o = 0, is_empty_o = 0. Then lane0 mispredicted (taken, predicted not-taken), lane1 correct and not-taken -> pbc_o = 10, branches_o = 2, map_o[1:0] = 2'b10.
5. PBC_W = 2, pred mode on, four correct single-lane branches -> pbc_o = 3 and the 4th branch goes to the map: branches_o = 1.
6. State with branches_o = 5, pbc_o = 2: assert rst_i together with flush_i and valid_i = 2'b11 -> all outputs at reset values next cycle.
